// File: rtl/tdm_mux_tx_pkg.sv
// rtl/tdm_mux_tx_pkg.sv - shared types and constants for the TDM transmitter
//
// Package tdm_pkg: FSM state enum, default channel count and the
// select-width derivation used by the interface, top and slot counter.
package tdm_pkg;

  localparam int N_CH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2
  } state_t;

  // Width of a channel index; kept at least 1 so a bus always exists.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_mux_tx_if.sv
// rtl/tdm_mux_tx_if.sv - parallel-in / serial-out bus bundle for tdm_mux_tx
//
// Signals:
//   din, din_valid, din_ready : parallel word handshake (source -> block)
//   d_out, sel_out            : serial bit and its channel index
//   out_valid                 : live slot on d_out/sel_out
//   frame_start               : slot 0 of a frame
//   par_slot                  : parity slot flag (TDM_MUX_TX_PARITY_EN builds)
// Modports: master = channel source / line observer, slave = transmitter.
interface tdm_mux_tx_if import tdm_pkg::*; #(
  parameter int N_CH = N_CH_DEFAULT
);
  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH-1:0]  din;
  logic             din_valid;
  logic             din_ready;
  logic             d_out;
  logic [SEL_W-1:0] sel_out;
  logic             out_valid;
  logic             frame_start;
  logic             par_slot;

  modport master (
    output din, din_valid,
    input  din_ready, d_out, sel_out, out_valid, frame_start, par_slot
  );

  modport slave (
    input  din, din_valid,
    output din_ready, d_out, sel_out, out_valid, frame_start, par_slot
  );

endinterface

// File: rtl/tdm_mux_tx_slot_cnt.sv
// rtl/tdm_mux_tx_slot_cnt.sv - slot counter with clear/enable and last-slot flag
//
// Module tdm_slot_cnt.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : force count to 0 (has priority over i_en)
//   i_en           : advance count by one
//   o_cnt          : current slot index
//   o_last         : o_cnt == N_CH-1
module tdm_slot_cnt import tdm_pkg::*; #(
  parameter  int N_CH = N_CH_DEFAULT,
  localparam int W    = sel_w(N_CH)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  localparam logic [W-1:0] LAST = W'(N_CH - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/tdm_mux_tx.sv
// rtl/tdm_mux_tx.sv - TDM transmitter: serializes one N_CH-bit word per frame
//
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : din/din_valid/din_ready in, d_out/sel_out/out_valid/
//                    frame_start/par_slot out
// Build option: TDM_MUX_TX_PARITY_EN adds an even-parity slot after each frame.
//
// r_state/slot counter describe the slot being prepared; the output registers
// present it one edge later. din_ready is decoded from that registered state,
// so a word accepted in the final slot starts its frame with no idle gap.
module tdm_mux_tx import tdm_pkg::*; #(
  parameter int N_CH = N_CH_DEFAULT
) (
  input logic         i_clk,
  input logic         i_rst_n,
  tdm_mux_tx_if.slave bus
);

  localparam int SEL_W = sel_w(N_CH);

  state_t           r_state, w_state_nxt;
  logic [N_CH-1:0]  r_shift, w_shift_nxt;
  logic             w_ready, w_accept;
  logic             w_cnt_clr, w_cnt_en, w_last;
  logic [SEL_W-1:0] w_cnt;

  logic             r_d_out, w_d_out_nxt;
  logic [SEL_W-1:0] r_sel_out, w_sel_out_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_frame_start, w_frame_start_nxt;
`ifdef TDM_MUX_TX_PARITY_EN
  logic             r_par, w_par_nxt;
  logic             r_par_slot, w_par_slot_nxt;
`endif

  tdm_slot_cnt #(.N_CH(N_CH)) u_slot_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_d_out       <= 1'b0;
      r_sel_out     <= '0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
`ifdef TDM_MUX_TX_PARITY_EN
      r_par         <= 1'b0;
      r_par_slot    <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_d_out       <= w_d_out_nxt;
      r_sel_out     <= w_sel_out_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_frame_start <= w_frame_start_nxt;
`ifdef TDM_MUX_TX_PARITY_EN
      r_par         <= w_par_nxt;
      r_par_slot    <= w_par_slot_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_ready           = 1'b0;
    w_cnt_clr         = 1'b0;
    w_cnt_en          = 1'b0;
    w_d_out_nxt       = 1'b0;
    w_sel_out_nxt     = '0;
    w_out_valid_nxt   = 1'b0;
    w_frame_start_nxt = 1'b0;
`ifdef TDM_MUX_TX_PARITY_EN
    w_par_nxt         = r_par;
    w_par_slot_nxt    = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
      end
      SEND: begin
        // Bit 0 of the shift register is always channel w_cnt.
        w_out_valid_nxt   = 1'b1;
        w_d_out_nxt       = r_shift[0];
        w_sel_out_nxt     = w_cnt;
        w_frame_start_nxt = (w_cnt == '0);
        w_shift_nxt       = r_shift >> 1;
        if (w_last) begin
`ifdef TDM_MUX_TX_PARITY_EN
          w_state_nxt = PAR;
`else
          w_ready     = 1'b1;
          w_state_nxt = IDLE;
`endif
        end else begin
          w_cnt_en = 1'b1;
        end
      end
`ifdef TDM_MUX_TX_PARITY_EN
      PAR: begin
        w_out_valid_nxt = 1'b1;
        w_d_out_nxt     = r_par;
        w_par_slot_nxt  = 1'b1;
        w_ready         = 1'b1;
        w_state_nxt     = IDLE;
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // An accept overrides the fall-back to IDLE and restarts the frame.
    w_accept = bus.din_valid && w_ready;
    if (w_accept) begin
      w_state_nxt = SEND;
      w_cnt_clr   = 1'b1;
      w_cnt_en    = 1'b0;
      w_shift_nxt = bus.din;
`ifdef TDM_MUX_TX_PARITY_EN
      w_par_nxt   = ^bus.din;
`endif
    end
  end

  assign bus.din_ready   = w_ready;
  assign bus.d_out       = r_d_out;
  assign bus.sel_out     = r_sel_out;
  assign bus.out_valid   = r_out_valid;
  assign bus.frame_start = r_frame_start;
`ifdef TDM_MUX_TX_PARITY_EN
  assign bus.par_slot    = r_par_slot;
`else
  assign bus.par_slot    = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_mux_tx.sv
// tb/tb_tdm_mux_tx.sv - self-checking bench for tdm_mux_tx
module tb_tdm_mux_tx;
  import tdm_pkg::*;

  localparam int N  = 8;
  localparam int SW = sel_w(N);
`ifdef TDM_MUX_TX_PARITY_EN
  localparam int FLEN = N + 1;
`else
  localparam int FLEN = N;
`endif

  typedef struct packed {
    logic          d;
    logic [SW-1:0] sel;
    logic          fs;
    logic          ps;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_mux_tx_if #(.N_CH(N)) bus ();

  tdm_mux_tx #(.N_CH(N)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int     errors = 0;
  int     checks = 0;
  slot_t  exp_q[$];
  logic [N-1:0] frame_bits = '0;
  logic [N-1:0] last_frame = '0;
  logic   last_par = 1'b0;
  int     run_len = 0;
  int     last_run = 0;
  int     fs_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected line activity of one accepted word: N data slots in ascending
  // channel order, then the parity slot when that build option is on.
  task automatic push_word(input logic [N-1:0] w);
    slot_t s;
    for (int i = 0; i < N; i++) begin
      s.d   = w[i];
      s.sel = SW'(i);
      s.fs  = (i == 0);
      s.ps  = 1'b0;
      exp_q.push_back(s);
    end
`ifdef TDM_MUX_TX_PARITY_EN
    s.d   = ^w;
    s.sel = '0;
    s.fs  = 1'b0;
    s.ps  = 1'b1;
    exp_q.push_back(s);
`endif
  endtask

  // Compare process: every edge, pops the slot the line must show after it.
  initial begin
    logic         pre_rst, pre_acc, pre_ready, ev;
    logic [N-1:0] pre_din;
    slot_t        e;
    forever begin
      @(posedge clk);
      pre_rst   = !rst_n;
      pre_ready = bus.din_ready;
      pre_acc   = rst_n && bus.din_valid && bus.din_ready;
      pre_din   = bus.din;
      if (!pre_rst)
        chk("din_ready", pre_ready, (exp_q.size() <= 1));
      #1;
      if (pre_rst) exp_q.delete();
      ev = 1'b0;
      e  = '0;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ev = 1'b1;
      end
      chk("out_valid", bus.out_valid, ev);
      chk("d_out", bus.d_out, e.d);
      chk("sel_out", bus.sel_out, e.sel);
      chk("frame_start", bus.frame_start, e.fs);
      chk("par_slot", bus.par_slot, e.ps);
      if (pre_acc) push_word(pre_din);

      if (bus.out_valid) begin
        run_len++;
        if (bus.frame_start) fs_total++;
        if (bus.par_slot) begin
          last_par = bus.d_out;
        end else begin
          frame_bits[bus.sel_out] = bus.d_out;
          if (bus.sel_out == SW'(N - 1)) last_frame = frame_bits;
        end
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  // Holds din_valid with word w until it is accepted; returns on the negedge
  // after the accepting edge with din_valid still high.
  task automatic send_word(input logic [N-1:0] w);
    logic acc;
    int   n;
    bus.din       = w;
    bus.din_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      @(posedge clk);
      acc = bus.din_ready && rst_n;
      @(negedge clk);
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int fs0;
    int n;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_din_ready", bus.din_ready, 1'b1);
    chk("rst_sel_out", bus.sel_out, '0);
    chk("rst_d_out", bus.d_out, 1'b0);
    chk("rst_frame_start", bus.frame_start, 1'b0);
    chk("rst_par_slot", bus.par_slot, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_out_valid", bus.out_valid, 1'b0);

    // Single word.
    send_word(8'b1010_0110);
    bus.din_valid = 1'b0;
    repeat (FLEN + 3) @(negedge clk);
    chk("single_bits", last_frame, 8'hA6);
    chk("single_len", last_run, FLEN);
    chk("single_idle", bus.out_valid, 1'b0);

    // Back-to-back frames with din_valid held.
    fs0 = fs_total;
    send_word(8'hFF);
    send_word(8'h00);
    bus.din_valid = 1'b0;
    repeat (2 * FLEN + 3) @(negedge clk);
    chk("b2b_len", last_run, 2 * FLEN);
    chk("b2b_fs_count", fs_total - fs0, 2);
    chk("b2b_last_bits", last_frame, 8'h00);

    // Backpressure: din churns while din_ready is low.
    send_word(8'h5C);
    for (int i = 0; i < 6; i++) begin
      bus.din       = N'($urandom);
      bus.din_valid = 1'b1;
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    repeat (FLEN + 3) @(negedge clk);
    chk("bp_bits", last_frame, 8'h5C);
    chk("bp_len", last_run, FLEN);

    // Reset while slot 3 is on the line; offered word is dropped.
    send_word(8'hC3);
    bus.din_valid = 1'b0;
    n = 0;
    while (!(bus.out_valid && bus.sel_out == SW'(3)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("slot3_timeout", 32'd0, 32'd1);
    rst_n         = 1'b0;
    bus.din       = 8'hAA;
    bus.din_valid = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_sel_out", bus.sel_out, '0);
    rst_n         = 1'b1;
    bus.din_valid = 1'b0;
    repeat (FLEN + 3) @(negedge clk);
    chk("abort_len", last_run, 4);
    chk("abort_stays_idle", bus.out_valid, 1'b0);

`ifdef TDM_MUX_TX_PARITY_EN
    send_word(8'b0000_0111);
    bus.din_valid = 1'b0;
    repeat (FLEN + 3) @(negedge clk);
    chk("par_07", last_par, 1'b1);
    chk("par_07_len", last_run, 9);
    send_word(8'h03);
    bus.din_valid = 1'b0;
    repeat (FLEN + 3) @(negedge clk);
    chk("par_03", last_par, 1'b0);
    chk("par_03_len", last_run, 9);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      bus.din       = N'($urandom);
      bus.din_valid = ($urandom_range(0, 3) != 0);
      rst_n         = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    rst_n         = 1'b1;
    bus.din_valid = 1'b0;
    repeat (FLEN + 4) @(negedge clk);
    chk("final_idle", bus.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
